// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared TPU types and constants
// Purpose: common word/address types for the accumulator datapath, the
//          accumulator register file read latency shared by the register
//          file integration and its read master, and the read-master FSM
//          state encoding.
// Ports:   none (package).
package tpu_pkg;

  localparam int BYTE_WIDTH         = 8;
  localparam int TPU_MATRIX_WIDTH   = 14;
  localparam int TPU_REGISTER_DEPTH = 512;
  localparam int ACC_ADDR_WIDTH     = $clog2(TPU_REGISTER_DEPTH);

  // Enabled cycles from read address to valid data_out:
  // 6 address-pipe stages plus the memory output register.
  localparam int ACC_READ_LATENCY   = 7;

  typedef logic [BYTE_WIDTH-1:0]     word_type;
  typedef logic [ACC_ADDR_WIDTH-1:0] accumulator_addr_type;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_ISSUE = 2'd1,
    RD_DRAIN = 2'd2
  } acc_rd_state_e;

  // Row address increment with wrap at the last implemented row.
  function automatic accumulator_addr_type acc_addr_inc(
    input accumulator_addr_type addr,
    input accumulator_addr_type last_addr
  );
    return (addr == last_addr) ? '0 : addr + 1'b1;
  endfunction

endpackage

// File: rtl/acc_row_fifo.sv
// rtl/acc_row_fifo.sv - first-word-fall-through row buffer
// Purpose: small FWFT FIFO holding accumulator rows (plus tag bits) between
//          the register file return path and the output stream.
// Ports:   i_clk, i_rst_n     clock, asynchronous active-low reset
//          i_push, i_data     write one entry
//          i_pop              consume head entry (ignored when empty)
//          o_data             head entry, valid while !o_empty
//          o_empty, o_count   occupancy status
module acc_row_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_do_pop;

  assign o_empty  = (r_count == '0);
  assign w_full   = (r_count == CNT_FULL);
  assign w_do_pop = i_pop && !o_empty;
  assign o_data   = r_mem[r_rd_ptr];
  assign o_count  = r_count;

  // Storage is not reset: entries are only observed behind a valid count.
  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({i_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // The producer reserves space before issuing, so a push into a full
  // buffer means the credit accounting upstream is broken.
  assert property (@(posedge i_clk) disable iff (!i_rst_n) !(i_push && w_full));

endmodule

// File: rtl/accumulator_reader.sv
// rtl/accumulator_reader.sv - read-side master for the accumulator register file
// Purpose: accepts a (base row, row count) command, issues one read address per
//          enabled cycle to the register file, tracks the fixed read latency,
//          buffers returning rows and streams them out in order under
//          valid/ready backpressure. Reads are only issued against reserved
//          buffer space, so no row is ever dropped.
// Ports:   clk, rst                 clock, asynchronous active-low reset
//          enable                   register-file enable; gates issue and tracker
//          cmd_valid/cmd_ready      command handshake
//          cmd_base_addr/cmd_length first row, number of rows (0 legal)
//          rf_read_addr             registered read address to the register file
//          rf_data_out              row returned by the register file
//          out_valid/out_ready      row stream handshake
//          out_data/out_last        row data, final-row marker
//          busy                     command in progress
//          done                     one-cycle pulse when a command has drained
module accumulator_reader
  import tpu_pkg::*;
#(
  parameter int MATRIX_WIDTH   = TPU_MATRIX_WIDTH,
  parameter int REGISTER_DEPTH = TPU_REGISTER_DEPTH,
  parameter int READ_LATENCY   = ACC_READ_LATENCY,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   enable,
  input  logic                                   cmd_valid,
  output logic                                   cmd_ready,
  input  accumulator_addr_type                   cmd_base_addr,
  input  logic [15:0]                            cmd_length,
  output accumulator_addr_type                   rf_read_addr,
  input  logic [MATRIX_WIDTH-1:0][BYTE_WIDTH-1:0] rf_data_out,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [MATRIX_WIDTH-1:0][BYTE_WIDTH-1:0] out_data,
  output logic                                   out_last,
  output logic                                   busy,
  output logic                                   done
);

  localparam int ROW_W = MATRIX_WIDTH * BYTE_WIDTH;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam accumulator_addr_type ADDR_LAST = accumulator_addr_type'(REGISTER_DEPTH - 1);
  localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W + 1)'(FIFO_DEPTH);

  acc_rd_state_e        r_state;
  acc_rd_state_e        w_state_nxt;

  accumulator_addr_type r_next_addr;
  accumulator_addr_type r_rf_addr;
  logic [15:0]          r_remaining;

  // Flags travelling with the address currently on rf_read_addr, and the
  // tracker stages that follow the register file's internal pipeline.
  logic                    r_addr_valid;
  logic                    r_addr_last;
  logic [READ_LATENCY-1:0] r_trk_valid;
  logic [READ_LATENCY-1:0] r_trk_last;

  logic [CNT_W-1:0]     r_inflight;
  logic                 r_done;

  logic                 w_cmd_ready;
  logic                 w_accept;
  logic                 w_issue;
  logic                 w_done_set;
  logic                 w_credit_ok;
  logic [CNT_W:0]       w_used;
  logic                 w_push;
  logic                 w_pop;

  logic [ROW_W:0]       w_fifo_data;
  logic                 w_fifo_empty;
  logic [CNT_W-1:0]     w_fifo_count;
  logic                 w_fifo_last;

  // Credits: every issued read owns a buffer slot from issue until it is
  // popped, counted either as in flight or as FIFO occupancy.
  assign w_used      = {1'b0, r_inflight} + {1'b0, w_fifo_count};
  assign w_credit_ok = (w_used < CREDIT_MAX);

  // The oldest tracker stage lines up with valid rf_data_out.
  assign w_push      = enable && r_trk_valid[READ_LATENCY-1];
  assign w_pop       = out_valid && out_ready;
  assign w_fifo_last = w_fifo_data[ROW_W];

  always_comb begin
    w_state_nxt = r_state;
    w_cmd_ready = 1'b0;
    w_accept    = 1'b0;
    w_issue     = 1'b0;
    w_done_set  = 1'b0;
    case (r_state)
      RD_IDLE: begin
        w_cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_accept = 1'b1;
          if (cmd_length == 16'd0) begin
            w_done_set = 1'b1;
          end else begin
            w_state_nxt = RD_ISSUE;
          end
        end
      end
      RD_ISSUE: begin
        w_issue = enable && w_credit_ok;
        if (w_issue && (r_remaining == 16'd1)) begin
          w_state_nxt = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        // Rows leave in issue order, so popping the tagged last row means
        // the tracker and the buffer are both empty afterwards.
        if (w_pop && w_fifo_last) begin
          w_done_set  = 1'b1;
          w_state_nxt = RD_IDLE;
        end
      end
      default: begin
        w_state_nxt = RD_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RD_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_set;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_next_addr <= '0;
      r_rf_addr   <= '0;
      r_remaining <= '0;
    end else if (w_accept) begin
      r_next_addr <= cmd_base_addr;
      r_remaining <= cmd_length;
    end else if (w_issue) begin
      r_rf_addr   <= r_next_addr;
      r_next_addr <= acc_addr_inc(r_next_addr, ADDR_LAST);
      r_remaining <= r_remaining - 16'd1;
    end
  end

  // Everything here advances only on enabled cycles, exactly like the
  // register file pipeline it mirrors.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr_valid <= 1'b0;
      r_addr_last  <= 1'b0;
      r_trk_valid  <= '0;
      r_trk_last   <= '0;
    end else if (enable) begin
      r_addr_valid <= w_issue;
      r_addr_last  <= w_issue && (r_remaining == 16'd1);
      r_trk_valid  <= {r_trk_valid[READ_LATENCY-2:0], r_addr_valid};
      r_trk_last   <= {r_trk_last[READ_LATENCY-2:0], r_addr_last};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inflight <= '0;
    end else begin
      case ({w_issue, w_push})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  acc_row_fifo #(
    .WIDTH (ROW_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_row_fifo (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_push  (w_push),
    .i_data  ({r_trk_last[READ_LATENCY-1], rf_data_out}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign cmd_ready    = w_cmd_ready;
  assign rf_read_addr = r_rf_addr;
  assign out_valid    = !w_fifo_empty;
  assign out_data     = w_fifo_data[ROW_W-1:0];
  assign out_last     = out_valid && w_fifo_last;
  assign busy         = (r_state != RD_IDLE);
  assign done         = r_done;

endmodule
